fp_d2f_arbiter: RTL
===================

# fp_d2f_arbiter

Round-robin controller that shares one double-to-float conversion unit between NREQ requesters. It accepts one 64-bit operand and rounding mode per transaction and restarts the converter through the converter's active-low reset. It waits for `done`, returns the 32-bit result and exception flags on a single response channel, and guards each transaction with a timeout. It sits between the FPU issue logic and the converter instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 15, max RUN cycles to wait for converter `done`
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_double  in  64*NREQ  operand, requester i at [64i+63:64i]
- req_round  in  2*NREQ  rounding mode, requester i at [2i+1:2i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  $clog2(NREQ)  requester that owns the response
- rsp_float  out  32  converted result
- rsp_flags  out  4  {timeout, nan, overflow, underflow}
- cvt_reset_n  out  1  converter reset, active-low
- cvt_double  out  64  operand to converter
- cvt_rounding  out  2  rounding mode to converter
- cvt_done, cvt_float[31:0], cvt_nan, cvt_ovf, cvt_unf  in  converter outputs

## Operation
- States: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - cvt_reset_n=0.
  - If any req_valid, pick the winner: the first valid index at or after (last_grant+1) mod NREQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Latch req_double/req_round into the operand registers and the winner into rsp_id.
  - Update last_grant to the winner, then go to LAUNCH.
- LAUNCH: hold cvt_reset_n=0 for exactly one cycle with operands stable, clear the timeout counter, then go to RUN.
- RUN:
  - cvt_reset_n=1; the counter increments each cycle.
  - On the first cycle with cvt_done=1: capture cvt_float and flags, set timeout=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: rsp_float=32'h7FC00000, flags=4'b1000, go to RESP.
  - If done and expiry occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1, with all rsp_* held stable.
  - On rsp_valid&&rsp_ready, go to IDLE (cvt_reset_n drops low again).
- req_ready is 0 in every state except IDLE. There is no request queueing.
- cvt_double/cvt_rounding are driven from the operand registers and stay constant from LAUNCH through RESP.
- Converter flags are sampled only on the done cycle. Stale flag values from the converter are never forwarded.

## Timing
- Reset values (reset=0, async):
  - state=IDLE, last_grant=NREQ-1 (requester 0 has first priority).
  - req_ready=0 unless a valid request is present in IDLE.
  - rsp_valid=0, rsp_id=0, rsp_float=0, rsp_flags=0.
  - cvt_reset_n=0, operand registers=0, counter=0.
- Reset mid-transaction aborts it: no response, converter held in reset, arbitration restarts at requester 0.
- Handshake at cycle t (IDLE) → LAUNCH t+1 → RUN from t+2.
- Converter done arrives d cycles after reset release (d=2 for NaN/inf/overflow, 4 for normal).
- rsp_valid rises in the cycle after done is sampled: t+3+d.
- Minimum turnaround: rsp accepted at cycle r → IDLE at r+1 → next handshake at r+1.
- Timeout response: rsp_valid at t+2+TIMEOUT+1.
- Counter width $clog2(TIMEOUT+1). No wrap occurs because RUN exits at TIMEOUT.

## Structure
- fp_pkg holds:
  - the state enum (IDLE/LAUNCH/RUN/RESP);
  - rounding-mode constants RND_ZERO=0, RND_POS=1, RND_NEG=2, RND_NEAR=3;
  - the constant QNAN32=32'h7FC00000;
  - flag bit indices.
- Sub-module rr_arbiter (NREQ param): inputs req vector and last_grant; outputs one-hot grant and encoded index; purely combinational.
- The FSM, operand/result registers and counter live in fp_d2f_arbiter.

## Test plan
- Single request, operand 64'h3FF0000000000000 (1.0), round 0 from requester 2 → rsp_id=2, rsp_float=32'h3F800000, flags=0.
- All four requesters valid continuously → grants in order 0,1,2,3,0; each req_ready pulses once per grant.
- Operand 64'h7FF0000000000000 (+inf) → rsp_float=32'h7F800000, flags=0; rsp_valid 5 cycles after handshake.
- Converter stub that never asserts done, TIMEOUT=15 → rsp_float=32'h7FC00000, flags=4'b1000 at handshake+18.
- rsp_ready held 0 for 10 cycles → rsp_* stable, req_ready stays 0; next grant occurs in the cycle after acceptance.
- reset pulsed low during RUN → rsp_valid=0, cvt_reset_n=0 immediately; after release the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the double-to-float converter arbiter.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  typedef enum logic [1:0] {RND_ZERO, RND_POS, RND_NEG, RND_NEAR} rnd_t;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  localparam int unsigned FLAG_W       = 4;
  localparam int unsigned FLAG_UNF     = 0;
  localparam int unsigned FLAG_OVF     = 1;
  localparam int unsigned FLAG_NAN     = 2;
  localparam int unsigned FLAG_TIMEOUT = 3;

  typedef struct packed {
    logic [63:0] value;
    rnd_t        round;
  } cvt_req_t;

  typedef struct packed {
    logic [31:0]       value;
    logic [FLAG_W-1:0] flags;
  } cvt_rsp_t;

  // Assemble the response flag nibble from its named bits.
  function automatic logic [FLAG_W-1:0] make_flags(input logic timeout, input logic nan,
                                                   input logic ovf, input logic unf);
    logic [FLAG_W-1:0] f;
    f               = '0;
    f[FLAG_TIMEOUT] = timeout;
    f[FLAG_NAN]     = nan;
    f[FLAG_OVF]     = ovf;
    f[FLAG_UNF]     = unf;
    return f;
  endfunction

endpackage

// File: rtl/fp_d2f_arbiter_if.sv
// Request/response channel between the FPU issue logic and the converter arbiter.
interface fp_d2f_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_double;
  logic [2*NREQ-1:0]    req_round;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_float;
  logic [3:0]           rsp_flags;

  modport master (
    output req_valid, req_double, req_round, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_float, rsp_flags
  );

  modport slave (
    input  req_valid, req_double, req_round, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_float, rsp_flags
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic           found;
  logic [31:0]    cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_grant) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fp_d2f_arbiter.sv
// Shares one double-to-float converter among NREQ requesters; restarts the
// converter per transaction and bounds each conversion with a timeout.
module fp_d2f_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  fp_d2f_arbiter_if.slave   bus,
  output logic              cvt_reset_n,
  output logic [63:0]       cvt_double,
  output logic [1:0]        cvt_rounding,
  input  logic              cvt_done,
  input  logic [31:0]       cvt_float,
  input  logic              cvt_nan,
  input  logic              cvt_ovf,
  input  logic              cvt_unf
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  cvt_req_t        op_q, op_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  cvt_rsp_t        rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            cvt_reset_n_q, cvt_reset_n_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req_ready_c;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NREQ - 1);
      op_q          <= '0;
      rsp_id_q      <= '0;
      rsp_q         <= '0;
      rsp_valid_q   <= 1'b0;
      cvt_reset_n_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      op_q          <= op_d;
      rsp_id_q      <= rsp_id_d;
      rsp_q         <= rsp_d;
      rsp_valid_q   <= rsp_valid_d;
      cvt_reset_n_q <= cvt_reset_n_d;
      cnt_q         <= cnt_d;
    end
  end

  // Converter reset is registered: low in IDLE/LAUNCH, high from the first RUN cycle until acceptance.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    op_d          = op_q;
    rsp_id_d      = rsp_id_q;
    rsp_d         = rsp_q;
    rsp_valid_d   = rsp_valid_q;
    cvt_reset_n_d = cvt_reset_n_q;
    cnt_d         = cnt_q;
    req_ready_c   = '0;

    case (state_q)
      IDLE: begin
        cvt_reset_n_d = 1'b0;
        if (|bus.req_valid) begin
          req_ready_c = grant;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              op_d.value = bus.req_double[64*i +: 64];
              op_d.round = rnd_t'(bus.req_round[2*i +: 2]);
            end
          end
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d         = '0;
        cvt_reset_n_d = 1'b1;
        state_d       = RUN;
      end
      RUN: begin
        // done has priority over expiry in the same cycle
        if (cvt_done) begin
          rsp_d.value = cvt_float;
          rsp_d.flags = make_flags(1'b0, cvt_nan, cvt_ovf, cvt_unf);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_d.value = QNAN32;
          rsp_d.flags = make_flags(1'b1, 1'b0, 1'b0, 1'b0);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          cvt_reset_n_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_float = rsp_q.value;
  assign bus.rsp_flags = rsp_q.flags;

  assign cvt_reset_n   = cvt_reset_n_q;
  assign cvt_double    = op_q.value;
  assign cvt_rounding  = op_q.round;

endmodule
